// File: rtl/sprite_mixer_pkg.sv
// Shared types and constants for the sprite layer mixer.
// Provides the FSM state enum, layer-ID width helpers and default colour indices.
package sprite_mixer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_EMIT
    } mixer_state_e;

    localparam int DEF_TRANSP_IDX = 0;
    localparam int DEF_BG_IDX     = 1;

    // Width of out_layer: one extra code is needed for "background".
    function automatic int layer_id_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a plain layer index, never narrower than one bit.
    function automatic int layer_enc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_layer_mixer_if.sv
// Pixel request, sprite ROM and resolved-pixel signals of the sprite layer mixer.
// master = requester/ROM/frame-buffer side, slave = the mixer itself.
interface sprite_layer_mixer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 4
);
    localparam int LW = sprite_mixer_pkg::layer_id_w(NUM_LAYERS);

    logic                         in_valid;
    logic                         in_ready;
    logic [9:0]                   in_x;
    logic [9:0]                   in_y;
    logic [NUM_LAYERS-1:0]        in_hit;
    logic [NUM_LAYERS*ADDR_W-1:0] in_addr;

    logic [ADDR_W-1:0]            rom_addr;
    logic [IDX_W-1:0]             rom_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             out_idx;
    logic [LW-1:0]                out_layer;
    logic [9:0]                   out_x;
    logic [9:0]                   out_y;

    modport master (
        output in_valid, in_x, in_y, in_hit, in_addr, rom_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_idx, out_layer, out_x, out_y
    );

    modport slave (
        input  in_valid, in_x, in_y, in_hit, in_addr, rom_data, out_ready,
        output in_ready, rom_addr, out_valid, out_idx, out_layer, out_x, out_y
    );

endinterface

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins; any flags a non-zero vector.
// Latency: combinational. Backpressure: none.
// Used by the mixer to pick the highest-priority pending layer.
module lsb_priority_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Per-pixel sprite compositor: picks the top hit layer, fetches its texel, resolves to one palette index.
// Latency: 1 cycle (no hits) up to NUM_LAYERS*(ROM_LAT+1)+1 cycles; one pixel in flight, in_ready only in idle.
// Backpressure: out_valid holds all outputs stable until out_ready. Macro SPRITE_MIXER_FALLBACK_EN enables re-fetch on transparency.
module sprite_layer_mixer
    import sprite_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 4,
    parameter int ROM_LAT    = 2,
    parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(DEF_TRANSP_IDX),
    parameter logic [IDX_W-1:0] BG_IDX     = IDX_W'(DEF_BG_IDX)
) (
    input logic Clk50,
    input logic Reset_n,
    sprite_layer_mixer_if.slave bus
);

    localparam int LW    = layer_id_w(NUM_LAYERS);
    localparam int EW    = layer_enc_w(NUM_LAYERS);
    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [LW-1:0] BG_LAYER = LW'(NUM_LAYERS);

    mixer_state_e                 state_q;
    logic [NUM_LAYERS-1:0]        mask_q;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
    logic [EW-1:0]                cur_layer_q;
    logic [CNT_W-1:0]             wait_cnt_q;
    logic [ADDR_W-1:0]            rom_addr_q;
    logic                         out_valid_q;
    logic [IDX_W-1:0]             out_idx_q;
    logic [LW-1:0]                out_layer_q;
    logic [9:0]                   out_x_q;
    logic [9:0]                   out_y_q;

    logic [NUM_LAYERS-1:0]        clr_mask;
    logic [NUM_LAYERS-1:0]        enc_vec;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_src;
    logic [EW-1:0]                enc_idx;
    logic                         enc_any;
    logic [ADDR_W-1:0]            fetch_addr;

    // One encoder serves both the initial pick (from the request) and the
    // fallback pick (from the pending mask minus the layer just rejected).
    always_comb begin
        clr_mask   = mask_q & ~(NUM_LAYERS'(1) << cur_layer_q);
        enc_vec    = (state_q == S_IDLE) ? bus.in_hit  : clr_mask;
        addr_src   = (state_q == S_IDLE) ? bus.in_addr : addr_q;
        fetch_addr = addr_src[int'(enc_idx)*ADDR_W +: ADDR_W];
    end

    lsb_priority_enc #(
        .N  (NUM_LAYERS),
        .IW (EW)
    ) u_enc (
        .vec (enc_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            cur_layer_q <= '0;
            wait_cnt_q  <= '0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_layer_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mask_q  <= bus.in_hit;
                        addr_q  <= bus.in_addr;
                        out_x_q <= bus.in_x;
                        out_y_q <= bus.in_y;
                        if (enc_any) begin
                            rom_addr_q  <= fetch_addr;
                            cur_layer_q <= enc_idx;
                            state_q     <= S_FETCH;
                        end else begin
                            out_idx_q   <= BG_IDX;
                            out_layer_q <= BG_LAYER;
                            out_valid_q <= 1'b1;
                            state_q     <= S_EMIT;
                        end
                    end
                end
                S_FETCH: begin
                    wait_cnt_q <= '0;
                    state_q    <= (ROM_LAT > 1) ? S_WAIT : S_CHECK;
                end
                S_WAIT: begin
                    if (int'(wait_cnt_q) == ROM_LAT - 2) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (bus.rom_data != TRANSP_IDX) begin
                        out_idx_q   <= bus.rom_data;
                        out_layer_q <= LW'(cur_layer_q);
                        out_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        mask_q <= clr_mask;
`ifdef SPRITE_MIXER_FALLBACK_EN
                        if (enc_any) begin
                            rom_addr_q  <= fetch_addr;
                            cur_layer_q <= enc_idx;
                            state_q     <= S_FETCH;
                        end else begin
                            out_idx_q   <= BG_IDX;
                            out_layer_q <= BG_LAYER;
                            out_valid_q <= 1'b1;
                            state_q     <= S_EMIT;
                        end
`else
                        out_idx_q   <= BG_IDX;
                        out_layer_q <= BG_LAYER;
                        out_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
`endif
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_layer = out_layer_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Self-checking bench for sprite_layer_mixer: directed cases plus randomized pixels against a priority model.
module tb_sprite_layer_mixer;

    localparam int NL      = 4;
    localparam int AW      = 18;
    localparam int IW      = 4;
    localparam int ROM_LAT = 2;
    localparam int BG      = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_layer_mixer_if #(.NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW)) bus ();

    sprite_layer_mixer #(
        .NUM_LAYERS (NL),
        .ADDR_W     (AW),
        .IDX_W      (IW),
        .ROM_LAT    (ROM_LAT)
    ) dut (
        .Clk50   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Sprite ROM: indexed by the low address byte, ROM_LAT=2 register stages.
    logic [3:0] rom_mem [256];
    logic [3:0] rom_s1;
    always @(posedge clk) begin
        rom_s1       <= rom_mem[bus.rom_addr[7:0]];
        bus.rom_data <= rom_s1;
    end

    int checks = 0;
    int errors = 0;
    logic [NL*AW-1:0] addrs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Layer k's address gets k in bits [7:6] so the four texels never alias.
    task automatic new_addrs();
        for (int k = 0; k < NL; k++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            a[7:6] = 2'(k);
            addrs[k*AW +: AW] = a;
        end
    endtask

    function automatic logic [7:0] lo(input int k);
        logic [AW-1:0] a;
        a = addrs[k*AW +: AW];
        return a[7:0];
    endfunction

    // Reference: walk layers in priority order; a transparent texel either
    // moves on (fallback) or ends the search with background.
    task automatic ref_model(input logic [3:0] hit, output int idx, output int layer,
                             output int fetches);
        bit done;
        idx = BG; layer = NL; fetches = 0; done = 0;
        for (int k = 0; k < NL; k++) begin
            if (!done && hit[k]) begin
                fetches++;
                if (rom_mem[lo(k)] != 0) begin
                    idx = int'(rom_mem[lo(k)]);
                    layer = k;
                    done = 1;
                end else begin
`ifndef SPRITE_MIXER_FALLBACK_EN
                    done = 1;
`endif
                end
            end
        end
    endtask

    task automatic run_txn(input logic [3:0] hit, input logic [9:0] x, input logic [9:0] y,
                           input int hold);
        int e_idx, e_layer, e_fetch, e_lat, lat, first;
        ref_model(hit, e_idx, e_layer, e_fetch);
        e_lat = 1 + e_fetch * (ROM_LAT + 1);
        first = 0;
        for (int k = NL - 1; k >= 0; k--) if (hit[k]) first = k;
        chk("ready_before", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_hit   = hit;
        bus.in_addr  = addrs;
        bus.in_x     = x;
        bus.in_y     = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_hit   = 4'($urandom);
        bus.in_x     = 10'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            if (lat == 1) begin
                chk("rom_addr_c1", 32'(bus.rom_addr), 32'(addrs[first*AW +: AW]));
                chk("busy_ready", 32'(bus.in_ready), 0);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("idx", 32'(bus.out_idx), e_idx);
        chk("layer", 32'(bus.out_layer), e_layer);
        chk("x", 32'(bus.out_x), 32'(x));
        chk("y", 32'(bus.out_y), 32'(y));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_idx", 32'(bus.out_idx), e_idx);
            chk("hold_layer", 32'(bus.out_layer), e_layer);
            chk("hold_xy", {bus.out_x, bus.out_y}, {x, y});
            chk("hold_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 0);
        chk("post_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        int r_idx, r_layer, r_fetch;
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'd0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_hit    = '0;
        bus.in_addr   = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_idx", 32'(bus.out_idx), 0);
        chk("rst_layer", 32'(bus.out_layer), 0);
        chk("rst_xy", {bus.out_x, bus.out_y}, 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);

        // No hits: background in cycle 1.
        new_addrs();
        run_txn(4'b0000, 10'd100, 10'd50, 0);

        // Layer 1 opaque.
        new_addrs();
        rom_mem[lo(1)] = 4'd7;
        rom_mem[lo(2)] = 4'd3;
        run_txn(4'b0110, 10'd12, 10'd34, 0);

        // Layer 1 transparent, layer 2 = 9; result depends on the fallback build.
        new_addrs();
        rom_mem[lo(1)] = 4'd0;
        rom_mem[lo(2)] = 4'd9;
        run_txn(4'b0110, 10'd640, 10'd479, 1);

        // Output backpressure for 5 cycles.
        new_addrs();
        rom_mem[lo(0)] = 4'd15;
        run_txn(4'b1111, 10'd1, 10'd2, 5);

        // Reset pulsed during the ROM wait.
        new_addrs();
        rom_mem[lo(0)] = 4'd5;
        bus.in_valid = 1'b1;
        bus.in_hit   = 4'b0001;
        bus.in_addr  = addrs;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_hold_valid", 32'(bus.out_valid), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(4'b0001, 10'd7, 10'd8, 0);

        // Randomized pixels.
        for (int n = 0; n < 60; n++) begin
            new_addrs();
            for (int k = 0; k < NL; k++)
                rom_mem[lo(k)] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            ref_model(4'($urandom), r_idx, r_layer, r_fetch);
            run_txn(4'($urandom), 10'($urandom), 10'($urandom), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
